writeback: RTL and testbench
============================

Name: writeback

Overview:
- Final pipeline stage, directly downstream of the execute stage.
- Consumes the execute outputs (valid, write-back enable, destination register number, result data) and commits results into the architectural register file it owns.
- Provides two combinational read ports with same-cycle write bypass to the decode stage.
- After every reset, runs a clearing sweep over the register file and stalls execute until the sweep completes.

Parameters:
- NREG, 1<<`W_RD, number of architectural registers; must be ≤ 2^`W_RD.
- CNT_W, 32, width of the retire counter (only used with the optional feature).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- v_i  input  1  execute result valid.
- stall_o  output  1  stall to execute; 1 = execute must hold its outputs.
- wb_i  input  1  result must be written to the register file.
- rd_num_i  input  `W_RD  destination register number.
- rd_data_i  input  `WORD  result data.
- ra_num_i  input  `W_RD  read port A register number (from decode).
- ra_data_o  output  `WORD  read port A data.
- rb_num_i  input  `W_RD  read port B register number.
- rb_data_o  output  `WORD  read port B data.
- ready_o  output  1  1 once the clearing sweep has finished (state RUN).
- retire_cnt_o  output  CNT_W  retired-instruction count (present only with WB_RETIRE_CNT_EN).

Behaviour:
- Reset (rst==0 at a rising clk edge):
  - state <= INIT, sweep pointer <= 0, retire count <= 0.
  - Register file contents are not reset directly; the INIT sweep clears them.
  - Reset asserted mid-sweep or mid-RUN restarts the sweep from register 0.
- INIT state:
  - stall_o=1, ready_o=0; ra_data_o and rb_data_o read 0.
  - Each cycle writes 0 to regfile[ptr], then ptr <= ptr+1.
  - When ptr==NREG-1 is written, state <= RUN. The sweep takes exactly NREG cycles after reset is released.
  - v_i, wb_i and incoming data are ignored: no writes, no count.
- RUN state:
  - stall_o=0, ready_o=1. stall_o is a registered decode of state, so it has no combinational path from any input.
  - If v_i & wb_i: regfile[rd_num_i] <= rd_data_i at the clock edge.
  - v_i=0 or wb_i=0: no write.
  - rd_num_i ≥ NREG: write suppressed; instruction still counts as retired.
- Read ports (RUN):
  - Combinational read of regfile[ra_num_i] / regfile[rb_num_i].
  - Bypass: if v_i & wb_i & (rd_num_i==ra_num_i), then ra_data_o = rd_data_i in the same cycle. Same rule for port B. The bypass applies even when both ports address the same register.
  - Address ≥ NREG reads 0.
- No hardwired-zero register; every register index is writable.
- Latency:
  - Result visible on a read port in the same cycle via bypass.
  - Result visible from the array from the following cycle onward.
- Simultaneous events: reset has priority over writes. A write arriving in the same cycle as the INIT→RUN transition is ignored, because the state was still INIT at that edge.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - retire_cnt_o port exists.
  - The counter increments by 1 on every RUN cycle with v_i==1, regardless of wb_i.
  - The counter wraps from 2^CNT_W-1 to 0.
  - The counter is cleared on reset and holds during INIT.
- Undefined: no port, no counter logic; all other behaviour identical.

Test Plan:
- Reset with rst=0 for 2 cycles, then release with NREG=16 → stall_o=1 and ready_o=0 for exactly 16 cycles; then stall_o=0, ready_o=1; reading all 16 registers returns 0.
- RUN, v_i=1, wb_i=1, rd_num_i=3, rd_data_i=32'hDEADBEEF, ra_num_i=3 → ra_data_o=32'hDEADBEEF in the same cycle (bypass); next cycle with v_i=0, ra_data_o still 32'hDEADBEEF (from the array).
- RUN, v_i=1, wb_i=0, rd_num_i=5, rd_data_i=32'h1234 → register 5 stays 0; with WB_RETIRE_CNT_EN, retire_cnt_o increments by 1.
- Write 32'hA5A5 to register 7, then assert rst=0 for 1 cycle in RUN → sweep restarts, stall_o=1 for 16 cycles, register 7 reads 0 afterwards, retire_cnt_o=0.
- During INIT, v_i=1, wb_i=1, rd_num_i=2, rd_data_i=32'hFFFF → no write; register 2 reads 0 after RUN is entered; counter unchanged.
- With WB_RETIRE_CNT_EN and CNT_W=4: 17 consecutive valid RUN cycles → retire_cnt_o=1 (wrapped).

Source files
------------

// File: rtl/writeback_if.sv
// writeback_if: execute/decode-facing bundle of the writeback stage; retire count only with WB_RETIRE_CNT_EN
`ifndef W_RD
`define W_RD 4
`endif
`ifndef WORD
`define WORD 32
`endif
interface writeback_if
`ifdef WB_RETIRE_CNT_EN
  #(parameter int CNT_W = 32)
`endif
  ;
  logic v_i;
  logic stall_o;
  logic wb_i;
  logic [`W_RD-1:0] rd_num_i;
  logic [`WORD-1:0] rd_data_i;
  logic [`W_RD-1:0] ra_num_i;
  logic [`WORD-1:0] ra_data_o;
  logic [`W_RD-1:0] rb_num_i;
  logic [`WORD-1:0] rb_data_o;
  logic ready_o;
`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_o;
`endif
  modport slave(
    input v_i, wb_i, rd_num_i, rd_data_i, ra_num_i, rb_num_i,
    output stall_o, ra_data_o, rb_data_o, ready_o
`ifdef WB_RETIRE_CNT_EN
    , output retire_cnt_o
`endif
  );
  modport master(
    output v_i, wb_i, rd_num_i, rd_data_i, ra_num_i, rb_num_i,
    input stall_o, ra_data_o, rb_data_o, ready_o
`ifdef WB_RETIRE_CNT_EN
    , input retire_cnt_o
`endif
  );
endinterface

// File: rtl/writeback.sv
// writeback: final stage owning the register file, with post-reset clearing sweep; retire counter via WB_RETIRE_CNT_EN
`ifndef W_RD
`define W_RD 4
`endif
`ifndef WORD
`define WORD 32
`endif
module writeback #(
  parameter int NREG = 1 << `W_RD
`ifdef WB_RETIRE_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input logic clk,
  input logic rst,
  writeback_if.slave bus
);
  typedef enum logic {INIT, RUN} state_t;
  state_t r_state;
  logic r_stall, r_ready;
  logic [`W_RD-1:0] r_ptr;
  logic [`WORD-1:0] r_rf [NREG];
  logic w_run, w_wr, w_we, w_rd_ok, w_ra_ok, w_rb_ok;
  logic [`W_RD-1:0] w_waddr;
  assign w_run = r_state == RUN;
  assign w_wr = bus.v_i & bus.wb_i;
  assign w_rd_ok = 32'(bus.rd_num_i) < NREG;
  assign w_ra_ok = 32'(bus.ra_num_i) < NREG;
  assign w_rb_ok = 32'(bus.rb_num_i) < NREG;
  // the sweep shares the single write port with retiring results
  assign w_we = rst & (w_run ? w_wr & w_rd_ok : 1'b1);
  assign w_waddr = w_run ? bus.rd_num_i : r_ptr;
  always_ff @(posedge clk)
    if (w_we) r_rf[w_waddr] <= w_run ? bus.rd_data_i : '0;
  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= INIT;
      r_ptr <= '0;
      r_stall <= 1'b1;
      r_ready <= 1'b0;
    end else if (!w_run) begin
      r_ptr <= r_ptr + 1'b1;
      if (32'(r_ptr) == NREG - 1) begin
        r_state <= RUN;
        r_stall <= 1'b0;
        r_ready <= 1'b1;
      end
    end
  assign bus.stall_o = r_stall;
  assign bus.ready_o = r_ready;
  assign bus.ra_data_o = !(w_run && w_ra_ok) ? '0 :
                         (w_wr && bus.rd_num_i == bus.ra_num_i) ? bus.rd_data_i : r_rf[bus.ra_num_i];
  assign bus.rb_data_o = !(w_run && w_rb_ok) ? '0 :
                         (w_wr && bus.rd_num_i == bus.rb_num_i) ? bus.rd_data_i : r_rf[bus.rb_num_i];
`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= !rst ? '0 : r_cnt + CNT_W'(w_run & bus.v_i);
  assign bus.retire_cnt_o = r_cnt;
`endif
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed-vector bench for writeback; retire counter checks only with WB_RETIRE_CNT_EN
module tb_writeback;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  int n;
`ifdef WB_RETIRE_CNT_EN
  localparam int CNT_W = 4;
  writeback_if #(.CNT_W(CNT_W)) bus();
  writeback #(.CNT_W(CNT_W)) dut(.clk(clk), .rst(rst), .bus(bus));
`else
  writeback_if bus();
  writeback dut(.clk(clk), .rst(rst), .bus(bus));
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic wb, input logic [3:0] rd, input logic [31:0] d);
    bus.v_i = v;
    bus.wb_i = wb;
    bus.rd_num_i = rd;
    bus.rd_data_i = d;
  endtask
  task automatic count_sweep();
    n = 0;
    while (bus.stall_o && n < 100) begin
      chk("ready_in_init", 32'(bus.ready_o), 0);
      cyc();
      n++;
    end
    chk("sweep_len", n, 16);
  endtask
  initial begin
    drive(0, 0, 0, 0);
    bus.ra_num_i = 0;
    bus.rb_num_i = 0;
    cyc();
    cyc();
    chk("stall_rst", 32'(bus.stall_o), 1);
    chk("ready_rst", 32'(bus.ready_o), 0);
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_rst", 32'(bus.retire_cnt_o), 0);
`endif
    rst = 1'b1;
    count_sweep();
    chk("stall_run", 32'(bus.stall_o), 0);
    chk("ready_run", 32'(bus.ready_o), 1);
    for (int i = 0; i < 16; i++) begin
      bus.ra_num_i = 4'(i);
      bus.rb_num_i = 4'(15 - i);
      #1;
      chk($sformatf("clr_a%0d", i), bus.ra_data_o, 0);
      chk($sformatf("clr_b%0d", i), bus.rb_data_o, 0);
    end
    drive(1, 1, 3, 32'hDEADBEEF);
    bus.ra_num_i = 3;
    bus.rb_num_i = 3;
    #1;
    chk("byp_a", bus.ra_data_o, 32'hDEADBEEF);
    chk("byp_b", bus.rb_data_o, 32'hDEADBEEF);
    cyc();
    drive(0, 0, 0, 0);
    #1;
    chk("arr_a", bus.ra_data_o, 32'hDEADBEEF);
    drive(1, 0, 5, 32'h1234);
    bus.ra_num_i = 5;
    #1;
    chk("nowb_byp", bus.ra_data_o, 0);
    cyc();
    drive(0, 0, 0, 0);
    #1;
    chk("nowb_arr", bus.ra_data_o, 0);
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_nowb", 32'(bus.retire_cnt_o), 2);
`endif
    drive(1, 1, 9, 32'hCAFE);
    bus.ra_num_i = 3;
    bus.rb_num_i = 9;
    #1;
    chk("mix_a", bus.ra_data_o, 32'hDEADBEEF);
    chk("mix_b", bus.rb_data_o, 32'hCAFE);
    cyc();
    drive(1, 1, 7, 32'hA5A5);
    cyc();
    drive(0, 0, 0, 0);
    bus.ra_num_i = 7;
    #1;
    chk("r7", bus.ra_data_o, 32'hA5A5);
    chk("r9", bus.rb_data_o, 32'hCAFE);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("stall_rerst", 32'(bus.stall_o), 1);
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_rerst", 32'(bus.retire_cnt_o), 0);
`endif
    drive(1, 1, 2, 32'hFFFF);
    bus.ra_num_i = 2;
    bus.rb_num_i = 2;
    #1;
    chk("init_rd", bus.ra_data_o, 0);
    count_sweep();
    drive(0, 0, 0, 0);
    #1;
    chk("r2_after", bus.ra_data_o, 0);
    bus.ra_num_i = 7;
    bus.rb_num_i = 9;
    #1;
    chk("r7_after", bus.ra_data_o, 0);
    chk("r9_after", bus.rb_data_o, 0);
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_init", 32'(bus.retire_cnt_o), 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 17; i++) cyc();
    drive(0, 0, 0, 0);
    #1;
    chk("cnt_wrap", 32'(bus.retire_cnt_o), 1);
`endif
    drive(1, 1, 0, 32'h1);
    cyc();
    drive(1, 1, 15, 32'h2);
    cyc();
    drive(0, 0, 0, 0);
    bus.ra_num_i = 0;
    bus.rb_num_i = 15;
    #1;
    chk("r0", bus.ra_data_o, 32'h1);
    chk("r15", bus.rb_data_o, 32'h2);
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_end", 32'(bus.retire_cnt_o), 3);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
